alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
Parametrised successor to the ALU-source and writeback-select muxes. It picks the A and B ALU operands from register file, EX/MEM forward, MEM/WB forward or immediate. It detects load-use hazards and holds the selected operands in a valid/ready-handshaked output register feeding the EX stage. It sits between decode (ID) and execute (EX) in the pipelined CPU.

Parameters:
DW, 32, datapath width in bits
AW, 5, register address width
ZERO_REG_EN, 1, when 1 register address 0 is never forwarded and always reads as zero

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decode presents an operation
in_ready  out  1  stage accepts operation this cycle
rs_addr  in  AW  source A register address
rt_addr  in  AW  source B register address
rt_used  in  1  operation reads rt (R-type or store)
rs_data  in  DW  register file read A
rt_data  in  DW  register file read B
imm  in  DW  extended immediate
alu_src  in  1  1: B operand = imm; 0: B operand = forwarded rt
exm_wr_en  in  1  EX/MEM instruction writes a register
exm_waddr  in  AW  EX/MEM destination
exm_data  in  DW  EX/MEM ALU result
exm_is_load  in  1  EX/MEM instruction is a load (data not yet available)
wb_wr_en  in  1  MEM/WB instruction writes a register
wb_waddr  in  AW  MEM/WB destination
wb_data  in  DW  MEM/WB writeback value (already memtoreg-selected)
flush  in  1  synchronous kill of the held operation
out_valid  out  1  out_a/out_b/out_store valid
out_ready  in  1  EX accepts
out_a  out  DW  registered ALU operand A
out_b  out  DW  registered ALU operand B
out_store  out  DW  registered forwarded rt (store data), independent of alu_src
load_use_stall  out  1  combinational, hazard blocking acceptance this cycle

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: out_valid=0; out_a, out_b, out_store = 0.
- Forward select, per source (rs, rt), combinational, in priority order:
  - EX/MEM match (exm_wr_en && exm_waddr==addr && !exm_is_load) gives exm_data.
  - Otherwise MEM/WB match (wb_wr_en && wb_waddr==addr) gives wb_data.
  - Otherwise the register file value.
- With ZERO_REG_EN=1 and addr==0, the value is 0 regardless of forwards or register file.
- Load-use hazard = in_valid && exm_wr_en && exm_is_load && exm_waddr!=0 (when ZERO_REG_EN) && (exm_waddr==rs_addr || (rt_used && exm_waddr==rt_addr)).
  - load_use_stall = hazard.
  - MEM/WB must not be used to bypass a hazard on the same address.
- in_ready = !hazard && (!out_valid || out_ready).
- Accept (in_valid && in_ready) at a rising edge:
  - Register out_a = fwd_rs.
  - Register out_b = alu_src ? imm : fwd_rt.
  - Register out_store = fwd_rt.
  - Set out_valid=1.
- Latency: 1 cycle from acceptance to out_valid.
- Throughput: 1 per cycle when out_ready stays high.
- Held output (out_valid && !out_ready): the output register is stable, and no new acceptance occurs.
- out_valid && out_ready && no accept: out_valid clears next edge; data regs keep their old value.
- flush: out_valid cleared next edge and acceptance suppressed that cycle (flush overrides accept). in_ready is unaffected by flush.
- Hazard and held output in the same cycle: in_ready=0, and load_use_stall=1 still reports the hazard.
- Reset asserted mid-operation: outputs go to reset values immediately; no residual valid after deassertion.

Optional Feature:
FWD_CNT_EN: when defined, adds output fwd_cnt (32 bits, reset 0).
- Counts accepted operations where at least one used source (rs, or rt when rt_used) took an EX/MEM or MEM/WB forward.
- Saturates at all-ones; not cleared by flush.
When undefined, the port and the counter are absent, with no other behaviour change.

Test Plan:
- Reset: rst_n=0 mid-stream -> out_valid=0, out_a=out_b=out_store=0 without waiting for a clock edge.
- Plain pass: rs=3 (rs_data=0x11), rt=4 (rt_data=0x22), alu_src=0, no writes pending -> next cycle out_a=0x11, out_b=0x22, out_valid=1.
- Forward priority: exm(wr, addr 3, data 0xAA, !load) and wb(wr, addr 3, data 0xBB), rs=3 -> out_a=0xAA; with exm_wr_en=0 -> out_a=0xBB.
- alu_src and store data: rt=5 forwarded from wb (0x55), alu_src=1, imm=0x10 -> out_b=0x10, out_store=0x55.
- Load-use: exm_is_load=1, exm_waddr=3, rs=3 -> load_use_stall=1, in_ready=0, no capture. Next cycle exm cleared, wb_waddr=3, wb_data=0x77 -> accept with out_a=0x77.
- Zero register and backpressure: rs=0 with exm forward to addr 0 -> out_a=0. Hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0. flush -> out_valid=0 next edge.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ID->EX operand stage: per-source forwarding, load-use hazard detection and a
// valid/ready output register. Optional FWD_CNT_EN adds a saturating forward counter.

module alu_operand_fwd #(
    parameter int DW          = 32,
    parameter int AW          = 5,
    parameter int ZERO_REG_EN = 1
) (
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] rf_data,
    input  logic          exm_wr_en,
    input  logic [AW-1:0] exm_waddr,
    input  logic [DW-1:0] exm_data,
    input  logic          exm_is_load,
    input  logic          wb_wr_en,
    input  logic [AW-1:0] wb_waddr,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] data,
    output logic          fwd_hit,
    output logic          load_hit
);
    logic is_zero;
    logic exm_match;
    logic wb_match;

    assign is_zero   = (ZERO_REG_EN != 0) && (addr == '0);
    assign exm_match = exm_wr_en && (exm_waddr == addr);
    assign wb_match  = wb_wr_en && (wb_waddr == addr);

    // A load in EX/MEM has no data yet: it falls through here but load_hit stalls the op.
    always_comb begin
        data     = rf_data;
        fwd_hit  = 1'b0;
        load_hit = exm_match && exm_is_load && !is_zero;
        if (is_zero) begin
            data = '0;
        end else if (exm_match && !exm_is_load) begin
            data    = exm_data;
            fwd_hit = 1'b1;
        end else if (wb_match) begin
            data    = wb_data;
            fwd_hit = 1'b1;
        end
    end
endmodule

module alu_operand_stage #(
    parameter int DW          = 32,
    parameter int AW          = 5,
    parameter int ZERO_REG_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    input  logic          rt_used,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic [DW-1:0] imm,
    input  logic          alu_src,
    input  logic          exm_wr_en,
    input  logic [AW-1:0] exm_waddr,
    input  logic [DW-1:0] exm_data,
    input  logic          exm_is_load,
    input  logic          wb_wr_en,
    input  logic [AW-1:0] wb_waddr,
    input  logic [DW-1:0] wb_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [DW-1:0] out_store,
    output logic          load_use_stall
`ifdef FWD_CNT_EN
    ,
    output logic [31:0]   fwd_cnt
`endif
);
    localparam int NSRC = 2;

    // Source 0 is rs (always read), source 1 is rt (read only when rt_used).
    logic [NSRC-1:0][AW-1:0] src_addr;
    logic [NSRC-1:0][DW-1:0] src_rf;
    logic [NSRC-1:0][DW-1:0] src_fwd;
    logic [NSRC-1:0]         src_used;
    logic [NSRC-1:0]         fwd_hit;
    logic [NSRC-1:0]         load_hit;
    logic                    hazard;
    logic                    accept;
    logic                    any_fwd;

    assign src_addr = {rt_addr, rs_addr};
    assign src_rf   = {rt_data, rs_data};
    assign src_used = {rt_used, 1'b1};

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        alu_operand_fwd #(
            .DW          (DW),
            .AW          (AW),
            .ZERO_REG_EN (ZERO_REG_EN)
        ) u_fwd (
            .addr        (src_addr[g]),
            .rf_data     (src_rf[g]),
            .exm_wr_en   (exm_wr_en),
            .exm_waddr   (exm_waddr),
            .exm_data    (exm_data),
            .exm_is_load (exm_is_load),
            .wb_wr_en    (wb_wr_en),
            .wb_waddr    (wb_waddr),
            .wb_data     (wb_data),
            .data        (src_fwd[g]),
            .fwd_hit     (fwd_hit[g]),
            .load_hit    (load_hit[g])
        );
    end

    assign hazard         = in_valid && |(load_hit & src_used);
    assign load_use_stall = hazard;
    assign in_ready       = !hazard && (!out_valid || out_ready);
    assign accept         = in_valid && in_ready && !flush;
    assign any_fwd        = |(fwd_hit & src_used);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_a     <= '0;
            out_b     <= '0;
            out_store <= '0;
        end else if (accept) begin
            out_a     <= src_fwd[0];
            out_b     <= alu_src ? imm : src_fwd[1];
            out_store <= src_fwd[1];
        end
    end

`ifdef FWD_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cnt <= '0;
        end else if (accept && any_fwd && (fwd_cnt != '1)) begin
            fwd_cnt <= fwd_cnt + 32'd1;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = any_fwd;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed cases followed by random traffic.
// Build with FWD_CNT_EN defined to also check the forward counter.

module tb_alu_operand_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  rs_addr, rt_addr;
    logic        rt_used;
    logic [31:0] rs_data, rt_data, imm;
    logic        alu_src;
    logic        exm_wr_en, exm_is_load;
    logic [4:0]  exm_waddr;
    logic [31:0] exm_data;
    logic        wb_wr_en;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_a, out_b, out_store;
    logic        load_use_stall;
`ifdef FWD_CNT_EN
    logic [31:0] fwd_cnt;
    logic [31:0] m_cnt;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
    } exp_t;

    exp_t q[$];
    logic m_vld;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rt_used        (rt_used),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .imm            (imm),
        .alu_src        (alu_src),
        .exm_wr_en      (exm_wr_en),
        .exm_waddr      (exm_waddr),
        .exm_data       (exm_data),
        .exm_is_load    (exm_is_load),
        .wb_wr_en       (wb_wr_en),
        .wb_waddr       (wb_waddr),
        .wb_data        (wb_data),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_a          (out_a),
        .out_b          (out_b),
        .out_store      (out_store),
        .load_use_stall (load_use_stall)
`ifdef FWD_CNT_EN
        ,
        .fwd_cnt        (fwd_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference forwarding, straight from the priority list: zero reg, EX/MEM non-load, MEM/WB, RF.
    function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return 32'd0;
        if (exm_wr_en && exm_waddr == a && !exm_is_load) return exm_data;
        if (wb_wr_en && wb_waddr == a) return wb_data;
        return rf;
    endfunction

    function automatic logic m_hit(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        return (exm_wr_en && exm_waddr == a && !exm_is_load) || (wb_wr_en && wb_waddr == a);
    endfunction

    // Monitor/scoreboard: runs at negedge, when inputs and outputs are settled.
    initial begin
        logic hz, rdy, acc;
        exp_t e;
        m_vld = 1'b0;
`ifdef FWD_CNT_EN
        m_cnt = '0;
`endif
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_vld = 1'b0;
                q.delete();
`ifdef FWD_CNT_EN
                m_cnt = '0;
`endif
            end else begin
                hz  = in_valid && exm_wr_en && exm_is_load && exm_waddr != 5'd0 &&
                      (exm_waddr == rs_addr || (rt_used && exm_waddr == rt_addr));
                rdy = !hz && (!m_vld || out_ready);
                acc = in_valid && rdy && !flush;
                chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
                chk("load_use_stall", {31'd0, load_use_stall}, {31'd0, hz});
                chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
`ifdef FWD_CNT_EN
                chk("fwd_cnt", fwd_cnt, m_cnt);
`endif
                if (m_vld) begin
                    if (q.size() == 0) begin
                        chk("scoreboard_empty", 32'd0, 32'd1);
                    end else begin
                        chk("out_a", out_a, q[0].a);
                        chk("out_b", out_b, q[0].b);
                        chk("out_store", out_store, q[0].s);
                        if (out_ready || flush) void'(q.pop_front());
                    end
                end
                if (acc) begin
                    e.a = m_fwd(rs_addr, rs_data);
                    e.s = m_fwd(rt_addr, rt_data);
                    e.b = alu_src ? imm : e.s;
                    q.push_back(e);
`ifdef FWD_CNT_EN
                    if ((m_hit(rs_addr) || (rt_used && m_hit(rt_addr))) && m_cnt != 32'hFFFF_FFFF)
                        m_cnt = m_cnt + 32'd1;
`endif
                end
                m_vld = flush ? 1'b0 : (acc ? 1'b1 : (out_ready ? 1'b0 : m_vld));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 0; rs_addr = 0; rt_addr = 0; rt_used = 0;
        rs_data = 0; rt_data = 0; imm = 0; alu_src = 0;
        exm_wr_en = 0; exm_waddr = 0; exm_data = 0; exm_is_load = 0;
        wb_wr_en = 0; wb_waddr = 0; wb_data = 0; flush = 0; out_ready = 1;
        #2;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_a", out_a, 32'd0);
        chk("rst_b", out_b, 32'd0);
        chk("rst_store", out_store, 32'd0);
        cyc();
        rst_n = 1'b1;

        // Plain pass
        in_valid = 1; rs_addr = 3; rs_data = 32'h11; rt_addr = 4; rt_data = 32'h22; rt_used = 1;
        cyc();
        chk("plain_a", out_a, 32'h11);
        chk("plain_b", out_b, 32'h22);
        chk("plain_valid", {31'd0, out_valid}, 32'd1);

        // Forward priority: EX/MEM over MEM/WB, then MEM/WB alone
        exm_wr_en = 1; exm_waddr = 3; exm_data = 32'hAA;
        wb_wr_en = 1; wb_waddr = 3; wb_data = 32'hBB;
        cyc();
        chk("prio_exm", out_a, 32'hAA);
        exm_wr_en = 0;
        cyc();
        chk("prio_wb", out_a, 32'hBB);

        // Immediate on B, forwarded rt on store
        rs_addr = 1; rs_data = 32'h1; rt_addr = 5; wb_waddr = 5; wb_data = 32'h55;
        alu_src = 1; imm = 32'h10;
        cyc();
        chk("imm_b", out_b, 32'h10);
        chk("imm_store", out_store, 32'h55);
        alu_src = 0;

        // Load-use stall, then MEM/WB supplies the loaded value
        wb_wr_en = 0; rs_addr = 3; rt_addr = 4;
        exm_wr_en = 1; exm_is_load = 1; exm_waddr = 3; exm_data = 32'hDEAD;
        #1;
        chk("lu_stall", {31'd0, load_use_stall}, 32'd1);
        chk("lu_ready", {31'd0, in_ready}, 32'd0);
        cyc();
        chk("lu_nocap", {31'd0, out_valid}, 32'd0);
        exm_wr_en = 0; exm_is_load = 0; wb_wr_en = 1; wb_waddr = 3; wb_data = 32'h77;
        cyc();
        chk("lu_wb", out_a, 32'h77);

        // Zero register ignores forwards
        wb_wr_en = 0; rs_addr = 0; rs_data = 32'h99;
        exm_wr_en = 1; exm_waddr = 0; exm_data = 32'hCC;
        cyc();
        chk("zero_a", out_a, 32'h0);

        // Backpressure: held output stays put
        exm_wr_en = 0; rs_addr = 1; rs_data = 32'h44; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_a", out_a, 32'h0);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
        end
        // Hazard while held still reports stall
        exm_wr_en = 1; exm_is_load = 1; exm_waddr = 1;
        #1;
        chk("hz_held_stall", {31'd0, load_use_stall}, 32'd1);
        exm_wr_en = 0; exm_is_load = 0;
        flush = 1;
        cyc();
        chk("flush_clr", {31'd0, out_valid}, 32'd0);
        out_ready = 1;
        cyc();
        chk("flush_noacc", {31'd0, out_valid}, 32'd0);
        flush = 0;

        // Reset mid-operation
        rs_addr = 2; rs_data = 32'h1234; out_ready = 0;
        cyc();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_a", out_a, 32'd0);
        chk("async_rst_b", out_b, 32'd0);
        chk("async_rst_store", out_store, 32'd0);
        cyc();
        rst_n = 1; in_valid = 0; out_ready = 1;
        cyc();
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

        // Random traffic, checked by the scoreboard
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            rs_addr     = 5'($urandom_range(0, 7));
            rt_addr     = 5'($urandom_range(0, 7));
            rt_used     = $urandom_range(0, 1) != 0;
            rs_data     = $urandom;
            rt_data     = $urandom;
            imm         = $urandom;
            alu_src     = $urandom_range(0, 1) != 0;
            exm_wr_en   = $urandom_range(0, 1) != 0;
            exm_waddr   = 5'($urandom_range(0, 7));
            exm_data    = $urandom;
            exm_is_load = ($urandom_range(0, 3) == 0);
            wb_wr_en    = $urandom_range(0, 1) != 0;
            wb_waddr    = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            cyc();
        end
        in_valid = 0; flush = 0; out_ready = 1;
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
